rx_session_ctrl: RTL and testbench

//  Sequences one receive session of the wake-up/sync front end: arm on a wake_up rising edge, wait a

---
 rtl/rx_session_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_rx_session_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_session_ctrl.sv
// rx_session_ctrl
// Sequences one receive session of the wake-up/sync front end. A wake_up
// rising edge arms the block. It then waits a bounded window for the first
// comparator rising edge, and after that clocks a fixed-length data frame.
// After the frame it ignores all edges for a hold-off period.
//
// Ports
//   clki         system clock, everything on posedge
//   rst_n        asynchronous active-low reset
//   en           session enable; low forces IDLE on the next edge
//   wake_up      async wake-up detector output (synchronised here)
//   comp_out     async comparator output, sync edge + data (synchronised here)
//   wu_valid     high while ARMED
//   data_clk_enb high while RX
//   data_clk     bit clock: 0 for phase < DIV/2, 1 otherwise (RX only)
//   bit_stb      one-cycle pulse at phase == DIV/2 (data_clk rise)
//   rx_bit       synchronised comp_out captured on bit_stb, held between strobes
//   bit_idx      current bit index 0..NBITS-1
//   in_preamble  RX and bit_idx < PRE_BITS
//   done         one-cycle pulse when the last bit period completes
//   timeout      one-cycle pulse when the ARMED window expires
//   busy         state != IDLE
//   state_dbg    current FSM state (IDLE=0, ARMED=1, RX=2, HOLDOFF=3)
//
// All outputs are registered. They are written in the same always_ff as the
// state, using the next-cycle value, so they line up with the state register.

module rx_session_ctrl #(
  parameter int DIV      = 100,
  parameter int TIMEOUT  = 20000,
  parameter int NBITS    = 1000,
  parameter int PRE_BITS = 192,
  parameter int HOLDOFF  = 1000,
  parameter int IW       = 10
) (
  input  logic          clki,
  input  logic          rst_n,
  input  logic          en,
  input  logic          wake_up,
  input  logic          comp_out,
  output logic          wu_valid,
  output logic          data_clk_enb,
  output logic          data_clk,
  output logic          bit_stb,
  output logic          rx_bit,
  output logic [IW-1:0] bit_idx,
  output logic          in_preamble,
  output logic          done,
  output logic          timeout,
  output logic          busy,
  output logic [1:0]    state_dbg
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] P_HALF = PW'(DIV / 2);
  localparam logic [HW-1:0] H_LAST = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam logic [IW-1:0] B_LAST = IW'(NBITS - 1);
  localparam logic [IW:0]   PRE_W  = (IW+1)'(PRE_BITS);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RX, S_HOLD} state_t;

  state_t        state;
  logic [2:0]    sw;
  logic [2:0]    sc;
  logic          wake_rise;
  logic          comp_rise;
  logic [TW-1:0] timer;
  logic [PW-1:0] phase;
  logic [HW-1:0] hold_cnt;
  logic [PW-1:0] phase_nx;
  logic [IW:0]   idx_nx;

  assign state_dbg = state;
  assign phase_nx  = phase + PW'(1);
  assign idx_nx    = {1'b0, bit_idx} + (IW+1)'(1);

  // 3-FF synchronisers. The rise flags are registered, so a pin first
  // sampled high at edge N is acted on by the FSM at edge N+3.
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      sw        <= '0;
      sc        <= '0;
      wake_rise <= 1'b0;
      comp_rise <= 1'b0;
    end else begin
      sw        <= {sw[1:0], wake_up};
      sc        <= {sc[1:0], comp_out};
      wake_rise <= (sw[2:1] == 2'b01);
      comp_rise <= (sc[2:1] == 2'b01);
    end
  end

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      timer        <= '0;
      phase        <= '0;
      hold_cnt     <= '0;
      bit_idx      <= '0;
      wu_valid     <= 1'b0;
      data_clk_enb <= 1'b0;
      data_clk     <= 1'b0;
      bit_stb      <= 1'b0;
      rx_bit       <= 1'b0;
      in_preamble  <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      bit_stb <= 1'b0;
      if (!en) begin
        // Abort from any state: no done/timeout pulse, counters cleared.
        state        <= S_IDLE;
        timer        <= '0;
        phase        <= '0;
        hold_cnt     <= '0;
        bit_idx      <= '0;
        wu_valid     <= 1'b0;
        data_clk_enb <= 1'b0;
        data_clk     <= 1'b0;
        in_preamble  <= 1'b0;
        busy         <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (wake_rise) begin
              state    <= S_ARMED;
              timer    <= '0;
              wu_valid <= 1'b1;
              busy     <= 1'b1;
            end
          end
          S_ARMED: begin
            // A comparator edge in the terminal cycle takes priority over expiry.
            if (comp_rise) begin
              state        <= S_RX;
              timer        <= '0;
              wu_valid     <= 1'b0;
              data_clk_enb <= 1'b1;
              data_clk     <= 1'b0;
              phase        <= '0;
              bit_idx      <= '0;
              in_preamble  <= (PRE_BITS > 0);
            end else if (timer == T_LAST) begin
              state    <= S_IDLE;
              timer    <= '0;
              wu_valid <= 1'b0;
              busy     <= 1'b0;
              timeout  <= 1'b1;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          S_RX: begin
            if (phase == P_LAST) begin
              phase    <= '0;
              data_clk <= 1'b0;
              if (bit_idx == B_LAST) begin
                done         <= 1'b1;
                bit_idx      <= '0;
                data_clk_enb <= 1'b0;
                in_preamble  <= 1'b0;
                if (HOLDOFF == 0) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                end else begin
                  state    <= S_HOLD;
                  hold_cnt <= '0;
                end
              end else begin
                bit_idx     <= bit_idx + IW'(1);
                in_preamble <= (idx_nx < PRE_W);
              end
            end else begin
              phase    <= phase_nx;
              data_clk <= (phase_nx >= P_HALF);
              if (phase_nx == P_HALF) begin
                bit_stb <= 1'b1;
                rx_bit  <= sc[2];
              end
            end
          end
          S_HOLD: begin
            if (hold_cnt == H_LAST) begin
              state    <= S_IDLE;
              hold_cnt <= '0;
              busy     <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_session_ctrl.sv
// Bench for rx_session_ctrl with small parameters. Expected event times are
// computed from the pin-to-action latency (pin first sampled at edge N, the
// FSM acts at edge N+3) and from the frame arithmetic: strobe k at
// RX entry + DIV/2 + k*DIV, done at RX entry + NBITS*DIV, idle after HOLDOFF.
module tb_rx_session_ctrl;

  localparam int DIV      = 16;
  localparam int TIMEOUT  = 200;
  localparam int NBITS    = 40;
  localparam int PRE_BITS = 12;
  localparam int HOLDOFF  = 30;
  localparam int IW       = 6;

  logic          clki = 1'b0;
  logic          rst_n, en, wake_up, comp_out;
  logic          wu_valid, data_clk_enb, data_clk, bit_stb, rx_bit;
  logic [IW-1:0] bit_idx;
  logic          in_preamble, done, timeout, busy;
  logic [1:0]    state_dbg;

  rx_session_ctrl #(
    .DIV(DIV), .TIMEOUT(TIMEOUT), .NBITS(NBITS),
    .PRE_BITS(PRE_BITS), .HOLDOFF(HOLDOFF), .IW(IW)
  ) dut (
    .clki(clki), .rst_n(rst_n), .en(en), .wake_up(wake_up), .comp_out(comp_out),
    .wu_valid(wu_valid), .data_clk_enb(data_clk_enb), .data_clk(data_clk),
    .bit_stb(bit_stb), .rx_bit(rx_bit), .bit_idx(bit_idx),
    .in_preamble(in_preamble), .done(done), .timeout(timeout), .busy(busy),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clki = ~clki;

  int cyc = 0;
  always @(posedge clki) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- monitor (samples on negedge) ----------------
  int stb_cyc_q[$];
  int stb_idx_q[$];
  bit stb_pre_q[$];
  bit stb_bit_q[$];
  int done_cnt = 0, to_cnt = 0, enb_cnt = 0, busy_cnt = 0, dclk_err = 0;
  int mon_rx = -1;

  always @(negedge clki) begin
    if (bit_stb) begin
      stb_cyc_q.push_back(cyc);
      stb_idx_q.push_back(int'(bit_idx));
      stb_pre_q.push_back(in_preamble);
      stb_bit_q.push_back(rx_bit);
    end
    if (done)         done_cnt++;
    if (timeout)      to_cnt++;
    if (data_clk_enb) enb_cnt++;
    if (busy)         busy_cnt++;
    if (data_clk_enb && mon_rx >= 0) begin
      if (data_clk !== (((cyc - mon_rx) % DIV) >= DIV / 2)) dclk_err++;
    end
    if (data_clk && !data_clk_enb) dclk_err++;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clki);
  endtask

  // mode 0: full frame, 1: en dropped mid-RX, 2: async reset mid-RX
  task automatic frame(input int gap, input int mode, output int done_c);
    int  w, rx, ab, n_exp, last_k, d0, t0;
    bit  data[NBITS];
    stb_cyc_q.delete(); stb_idx_q.delete(); stb_pre_q.delete(); stb_bit_q.delete();
    exp_q.delete();
    d0 = done_cnt; t0 = to_cnt;
    dclk_err = 0;
    done_c = 0;
    comp_out = 1'b0;
    wake_up  = 1'b1;
    w = cyc;
    wait_until(w + 3); check_eq("arm_early", wu_valid, 0);
    wait_until(w + 4); check_eq("arm", wu_valid, 1); check_eq("busy_arm", busy, 1);
    wait_until(w + 6); wake_up = 1'b0;
    wait_until(w + gap); comp_out = 1'b1;
    rx = w + gap + 4;
    mon_rx = rx;
    wait_until(rx - 1); check_eq("rx_early", data_clk_enb, 0);
    wait_until(rx);     check_eq("rx_entry", data_clk_enb, 1); check_eq("wu_drop", wu_valid, 0);
    ab = (mode != 0) ? $urandom_range(3 * NBITS / 4, NBITS / 4) : NBITS;
    for (int k = 0; k < NBITS; k++) data[k] = 1'($urandom_range(1, 0));
    last_k = (mode != 0) ? ab : NBITS - 1;
    for (int k = 0; k <= last_k; k++) begin
      wait_until(rx + DIV * k);
      comp_out = data[k];
      if (k == 5) wake_up = 1'b1;   // wake edge inside RX must be ignored
      if (k == 9) wake_up = 1'b0;
    end
    if (mode == 0) begin
      wait_until(rx + NBITS * DIV - 1);
      check_eq("done_early", done, 0); check_eq("enb_last", data_clk_enb, 1);
      wait_until(rx + NBITS * DIV);
      check_eq("done", done, 1); check_eq("enb_end", data_clk_enb, 0);
      check_eq("busy_hold", busy, 1); check_eq("idx_end", bit_idx, 0);
      check_eq("pre_end", in_preamble, 0);
      done_c = cyc;
      wait_until(done_c + 1); check_eq("done_pulse", done, 0);
      n_exp = NBITS;
    end else if (mode == 1) begin
      wait_until(rx + DIV * ab + 3);
      en = 1'b0;
      wait_until(rx + DIV * ab + 4);
      check_eq("en_busy", busy, 0); check_eq("en_enb", data_clk_enb, 0);
      check_eq("en_dclk", data_clk, 0); check_eq("en_idx", bit_idx, 0);
      wait_until(cyc + 2 * DIV);
      en = 1'b1;
      n_exp = ab;
    end else begin
      wait_until(rx + DIV * ab + DIV / 2 + 2);
      #3 rst_n = 1'b0;
      #1;
      check_eq("rst_busy", busy, 0); check_eq("rst_enb", data_clk_enb, 0);
      check_eq("rst_dclk", data_clk, 0); check_eq("rst_idx", bit_idx, 0);
      check_eq("rst_pre", in_preamble, 0);
      repeat (3) @(negedge clki);
      rst_n = 1'b1;
      wait_until(cyc + 2 * DIV);
      n_exp = ab + 1;
    end
    mon_rx = -1;
    for (int k = 0; k < n_exp; k++) exp_q.push_back(32'(rx + DIV / 2 + DIV * k));
    check_eq("stb_count", stb_cyc_q.size(), n_exp);
    for (int k = 0; k < n_exp && k < stb_cyc_q.size(); k++) begin
      check_eq("stb_time", stb_cyc_q[k], exp_q.pop_front());
      check_eq("stb_idx",  stb_idx_q[k], k);
      check_eq("stb_pre",  stb_pre_q[k], (k < PRE_BITS));
      check_eq("stb_bit",  stb_bit_q[k], data[k]);
    end
    check_eq("done_count", done_cnt - d0, (mode == 0) ? 1 : 0);
    check_eq("no_timeout", to_cnt - t0, 0);
    check_eq("dclk_shape", dclk_err, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d, w, b0, e0, t0, v;
    rst_n = 1'b0; en = 1'b0; wake_up = 1'b0; comp_out = 1'b0;
    repeat (5) @(negedge clki);
    check_eq("rst_wu", wu_valid, 0);     check_eq("rst_enb0", data_clk_enb, 0);
    check_eq("rst_dclk0", data_clk, 0);  check_eq("rst_stb", bit_stb, 0);
    check_eq("rst_rxbit", rx_bit, 0);    check_eq("rst_idx0", bit_idx, 0);
    check_eq("rst_pre0", in_preamble, 0); check_eq("rst_done", done, 0);
    check_eq("rst_to", timeout, 0);      check_eq("rst_busy0", busy, 0);
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (5) @(negedge clki);

    // Comparator activity with no wake-up leaves the block idle.
    b0 = busy_cnt;
    for (int i = 0; i < 40; i++) begin
      comp_out = 1'($urandom_range(1, 0));
      @(negedge clki);
    end
    comp_out = 1'b0;
    repeat (6) @(negedge clki);
    check_eq("idle_comp", busy_cnt - b0, 0);

    // Full frame, then edges inside HOLDOFF (including its last cycle) are dropped.
    frame($urandom_range(TIMEOUT - 1, 6), 0, d);
    wait_until(d + 5);  wake_up = 1'b1; comp_out = 1'b1;
    wait_until(d + 9);  wake_up = 1'b0; comp_out = 1'b0;
    wait_until(d + HOLDOFF - 4); wake_up = 1'b1;
    wait_until(d + HOLDOFF - 1); check_eq("hold_busy", busy, 1);
    wait_until(d + HOLDOFF);     check_eq("hold_end", busy, 0); check_eq("hold_wu", wu_valid, 0);
    wait_until(d + HOLDOFF + 3); check_eq("hold_drop", wu_valid, 0);
    wake_up = 1'b0;
    wait_until(d + HOLDOFF + 10);

    // Back-to-back: wake acted on in the first IDLE cycle after HOLDOFF.
    frame($urandom_range(TIMEOUT - 1, 6), 0, d);
    wait_until(d + HOLDOFF - 3);
    frame($urandom_range(TIMEOUT - 1, 6), 0, d);
    wait_until(d + HOLDOFF + 6);

    // Timeout: re-wake in ARMED does not restart the timer; comp one cycle late is ignored.
    e0 = enb_cnt; t0 = to_cnt;
    w = cyc; wake_up = 1'b1;
    wait_until(w + 4);  check_eq("to_arm", wu_valid, 1);
    wait_until(w + 6);  wake_up = 1'b0;
    wait_until(w + 20); wake_up = 1'b1;
    wait_until(w + 26); wake_up = 1'b0;
    wait_until(w + TIMEOUT + 1); comp_out = 1'b1;
    wait_until(w + TIMEOUT + 3); check_eq("to_early", timeout, 0); check_eq("to_wu", wu_valid, 1);
    wait_until(w + TIMEOUT + 4); check_eq("to_pulse", timeout, 1);
    check_eq("to_wu_drop", wu_valid, 0); check_eq("to_idle", busy, 0);
    wait_until(w + TIMEOUT + 5); check_eq("to_single", timeout, 0);
    wait_until(w + TIMEOUT + 12); check_eq("late_comp", busy, 0);
    check_eq("to_no_rx", enb_cnt - e0, 0);
    check_eq("to_count", to_cnt - t0, 1);
    comp_out = 1'b0;
    repeat (6) @(negedge clki);

    // Comparator edge in the terminal ARMED cycle wins over timeout.
    frame(TIMEOUT, 0, d);
    wait_until(d + HOLDOFF + 6);

    // en low in ARMED: idle next cycle, no timeout later.
    t0 = to_cnt;
    w = cyc; wake_up = 1'b1;
    wait_until(w + 4);  check_eq("en_arm", wu_valid, 1);
    wait_until(w + 6);  wake_up = 1'b0;
    wait_until(w + 30); en = 1'b0;
    wait_until(w + 31); check_eq("en_arm_wu", wu_valid, 0); check_eq("en_arm_busy", busy, 0);
    wait_until(w + TIMEOUT + 15); check_eq("en_arm_to", to_cnt - t0, 0);
    // Wake edge arriving in the same cycle en returns is accepted.
    v = cyc; wake_up = 1'b1;
    wait_until(v + 3); en = 1'b1;
    wait_until(v + 4); check_eq("en_rehigh", wu_valid, 1);
    wake_up = 1'b0; en = 1'b0;
    wait_until(v + 6); check_eq("en_rehigh_off", busy, 0);
    en = 1'b1;
    repeat (6) @(negedge clki);

    // en low mid-RX, then async reset mid-RX, then a normal session.
    frame($urandom_range(TIMEOUT - 1, 6), 1, d);
    repeat (10) @(negedge clki);
    frame($urandom_range(TIMEOUT - 1, 6), 2, d);
    repeat (10) @(negedge clki);
    frame($urandom_range(TIMEOUT - 1, 6), 0, d);
    wait_until(d + HOLDOFF + 1);
    check_eq("final_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
